// File: rtl/garage_pkg.sv
// Shared definitions for the garage entrance logic: detector FSM states and
// the default debounce / timeout constants.
package garage_pkg;

    typedef enum logic [2:0] {
        IDLE,
        IN_A,
        IN_AB,
        IN_B,
        OUT_B,
        OUT_BA,
        OUT_A,
        WAIT_CLEAR
    } state_t;

    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 4;
    localparam int unsigned DEFAULT_TIMEOUT_CYCLES  = 1000;

endpackage

// File: rtl/sensor_debounce.sv
// Two-flop synchronizer followed by a debouncer that only adopts a new level
// after it has persisted for DEBOUNCE_CYCLES consecutive cycles.
module sensor_debounce
    import garage_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset_n,
    input  logic sensor_raw_i,
    output logic level_o
);

    localparam int unsigned       CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             level_q;
    logic             level_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sensor_raw_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    // Any cycle where the synchronized input agrees with the level restarts the run.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign level_o = level_q;

endmodule

// File: rtl/car_detector.sv
// Two-beam car direction detector: debounces both sensors, tracks the beam
// sequence in an FSM and emits one pulse per completed entry or exit.
module car_detector
    import garage_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned TIMEOUT_CYCLES  = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic reset_n,
    input  logic sensor_a,
    input  logic sensor_b,
    output logic entry_detected,
    output logic exit_detected,
    output logic busy,
    output logic fault
);

    localparam int unsigned        DWELL_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [DWELL_W-1:0] DWELL_LIMIT = DWELL_W'(TIMEOUT_CYCLES);

    logic               aLevel;
    logic               bLevel;
    logic [1:0]         ab;
    state_t             state_q;
    state_t             state_d;
    logic [DWELL_W-1:0] dwell_q;
    logic [DWELL_W-1:0] dwell_d;
    logic               entry_q;
    logic               entry_d;
    logic               exit_q;
    logic               exit_d;
    logic               fault_q;
    logic               timeout_d;
    logic               tracking;

    sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
        .clk          (clk),
        .reset_n      (reset_n),
        .sensor_raw_i (sensor_a),
        .level_o      (aLevel)
    );

    sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
        .clk          (clk),
        .reset_n      (reset_n),
        .sensor_raw_i (sensor_b),
        .level_o      (bLevel)
    );

    assign ab       = {aLevel, bLevel};
    assign tracking = (state_q != IDLE) && (state_q != WAIT_CLEAR);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            dwell_q <= '0;
            entry_q <= 1'b0;
            exit_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            dwell_q <= dwell_d;
            entry_q <= entry_d;
            exit_q  <= exit_d;
            fault_q <= fault_q | timeout_d;
        end
    end

    // A timeout overrides whatever the sensors are doing; unlisted combinations hold state.
    always_comb begin
        state_d   = state_q;
        entry_d   = 1'b0;
        exit_d    = 1'b0;
        timeout_d = 1'b0;
        if (tracking && (dwell_q == DWELL_LIMIT)) begin
            state_d   = WAIT_CLEAR;
            timeout_d = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (ab == 2'b10)      state_d = IN_A;
                    else if (ab == 2'b01) state_d = OUT_B;
                    else if (ab == 2'b11) state_d = WAIT_CLEAR;
                end
                IN_A: begin
                    if (ab == 2'b11)      state_d = IN_AB;
                    else if (ab == 2'b00) state_d = IDLE;
                end
                IN_AB: begin
                    if (ab == 2'b01)      state_d = IN_B;
                    else if (ab == 2'b10) state_d = IN_A;
                end
                IN_B: begin
                    if (ab == 2'b11) begin
                        state_d = IN_AB;
                    end else if (ab == 2'b00) begin
                        state_d = IDLE;
                        entry_d = 1'b1;
                    end
                end
                OUT_B: begin
                    if (ab == 2'b11)      state_d = OUT_BA;
                    else if (ab == 2'b00) state_d = IDLE;
                end
                OUT_BA: begin
                    if (ab == 2'b10)      state_d = OUT_A;
                    else if (ab == 2'b01) state_d = OUT_B;
                end
                OUT_A: begin
                    if (ab == 2'b11) begin
                        state_d = OUT_BA;
                    end else if (ab == 2'b00) begin
                        state_d = IDLE;
                        exit_d  = 1'b1;
                    end
                end
                WAIT_CLEAR: begin
                    if (ab == 2'b00) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        dwell_d = dwell_q;
        if (!tracking || (state_d != state_q)) begin
            dwell_d = '0;
        end else if (dwell_q != DWELL_LIMIT) begin
            dwell_d = dwell_q + 1'b1;
        end
    end

    always_comb begin
        busy           = (state_q != IDLE);
        entry_detected = entry_q;
        exit_detected  = exit_q;
        fault          = fault_q;
    end

endmodule

// File: tb/tb_car_detector.sv
// Directed bench for car_detector: expected pulses (kind and cycle) are queued
// as stimulus is driven and matched against pulses captured from the DUT.
module tb_car_detector;

    typedef struct {
        logic isEntry;
        int   cycle;
    } pulse_t;

    logic clk;
    logic reset_n;
    logic sensor_a;
    logic sensor_b;
    logic entry_detected;
    logic exit_detected;
    logic busy;
    logic fault;

    int     vectors     = 0;
    int     miscompares = 0;
    int     cyc         = 0;
    int     bothHigh    = 0;
    pulse_t expQ[$];
    pulse_t obsQ[$];

    car_detector dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .sensor_a       (sensor_a),
        .sensor_b       (sensor_b),
        .entry_detected (entry_detected),
        .exit_detected  (exit_detected),
        .busy           (busy),
        .fault          (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Capture every pulse with the count of rising edges seen so far.
    always @(negedge clk) begin
        if (entry_detected === 1'b1) obsQ.push_back('{1'b1, cyc});
        if (exit_detected === 1'b1)  obsQ.push_back('{1'b0, cyc});
        if (entry_detected === 1'b1 && exit_detected === 1'b1) bothHigh++;
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic a, input logic b, input int n);
        sensor_a = a;
        sensor_b = b;
        repeat (n) @(negedge clk);
    endtask

    task automatic expectPulse(input logic isEntry);
        expQ.push_back('{isEntry, cyc + 7});
    endtask

    task automatic checkOutput(input string tag);
        pulse_t e;
        pulse_t o;
        check({tag, "_pulses"}, obsQ.size(), expQ.size());
        while (expQ.size() > 0 && obsQ.size() > 0) begin
            e = expQ.pop_front();
            o = obsQ.pop_front();
            check({tag, "_kind"}, o.isEntry, e.isEntry);
            check({tag, "_cycle"}, o.cycle, e.cycle);
        end
        expQ.delete();
        obsQ.delete();
    endtask

    initial begin
        reset_n  = 1'b0;
        sensor_a = 1'b0;
        sensor_b = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_entry", entry_detected, 0);
        check("rst_exit", exit_detected, 0);
        check("rst_busy", busy, 0);
        check("rst_fault", fault, 0);
        reset_n = 1'b1;
        applyStimulus(0, 0, 5);

        // Inbound pass
        applyStimulus(1, 0, 10);
        check("in_busy_a", busy, 1);
        applyStimulus(1, 1, 10);
        applyStimulus(0, 1, 10);
        expectPulse(1'b1);
        applyStimulus(0, 0, 10);
        checkOutput("inbound");
        check("in_busy_end", busy, 0);

        // Outbound pass
        applyStimulus(0, 1, 10);
        check("out_busy_b", busy, 1);
        applyStimulus(1, 1, 10);
        check("out_busy_ba", busy, 1);
        applyStimulus(1, 0, 10);
        expectPulse(1'b0);
        applyStimulus(0, 0, 6);
        check("out_busy_before_pulse", busy, 1);
        applyStimulus(0, 0, 4);
        checkOutput("outbound");
        check("out_busy_end", busy, 0);

        // Short glitch is filtered, then an abort from IN_A
        applyStimulus(1, 0, 3);
        applyStimulus(0, 0, 10);
        check("glitch_busy", busy, 0);
        applyStimulus(1, 0, 10);
        check("abort_busy_a", busy, 1);
        applyStimulus(0, 0, 10);
        check("abort_busy_end", busy, 0);
        checkOutput("glitch_abort");

        // Back-out followed by a full inbound pass
        applyStimulus(1, 0, 10);
        applyStimulus(1, 1, 10);
        applyStimulus(1, 0, 10);
        applyStimulus(0, 0, 10);
        check("backout_busy", busy, 0);
        checkOutput("backout");
        applyStimulus(1, 0, 10);
        applyStimulus(1, 1, 10);
        applyStimulus(0, 1, 10);
        expectPulse(1'b1);
        applyStimulus(0, 0, 10);
        checkOutput("after_backout");

        // Timeout while dwelling in IN_A
        applyStimulus(1, 0, 500);
        check("to_fault_early", fault, 0);
        check("to_busy_early", busy, 1);
        applyStimulus(1, 0, 600);
        check("to_fault", fault, 1);
        check("to_busy_wait", busy, 1);
        applyStimulus(0, 0, 10);
        check("to_busy_end", busy, 0);
        check("to_fault_sticky", fault, 1);
        checkOutput("timeout");

        // Reset in the middle of an inbound passage
        applyStimulus(1, 0, 10);
        applyStimulus(1, 1, 10);
        check("mid_busy", busy, 1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_fault", fault, 0);
        check("mid_rst_entry", entry_detected, 0);
        applyStimulus(0, 0, 5);
        reset_n = 1'b1;
        applyStimulus(0, 0, 20);
        check("mid_busy_after", busy, 0);
        check("mid_fault_after", fault, 0);
        checkOutput("mid_reset");

        // Car straddling both beams across reset release
        sensor_a = 1'b1;
        sensor_b = 1'b1;
        reset_n  = 1'b0;
        applyStimulus(1, 1, 3);
        reset_n = 1'b1;
        applyStimulus(1, 1, 20);
        check("straddle_busy", busy, 1);
        applyStimulus(0, 1, 10);
        check("straddle_busy_b", busy, 1);
        applyStimulus(0, 0, 10);
        check("straddle_busy_end", busy, 0);
        checkOutput("straddle");

        check("never_both_high", bothHigh, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/car_detector.md
CAR_DETECTOR -- requirements
Module: car_detector

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4: consecutive stable cycles before a debounced sensor level changes.
REQ-002 Parameter TIMEOUT_CYCLES, default 1000: maximum cycles the block may dwell in one non-idle state before it declares a fault.
REQ-003 clk  input  1  single clock; all state is updated on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 sensor_a  input  1  raw outer beam sensor, 1 = blocked; asynchronous to clk.
REQ-006 sensor_b  input  1  raw inner beam sensor, 1 = blocked; asynchronous to clk.
REQ-007 entry_detected  output  1  one-cycle pulse per completed inbound passage; feeds the car counter.
REQ-008 exit_detected  output  1  one-cycle pulse per completed outbound passage; feeds the car counter.
REQ-009 busy  output  1  level, high while the FSM is in any state other than IDLE.
REQ-010 fault  output  1  sticky level, high after a timeout.

Function
REQ-011 Each sensor SHALL pass through a 2-flop synchronizer and then a debouncer.
REQ-012 The debounced level SHALL take the synchronized value only after that value has differed from the debounced level for DEBOUNCE_CYCLES consecutive cycles; any mismatch-free cycle restarts the count.
REQ-013 The FSM states SHALL be IDLE, IN_A, IN_AB, IN_B, OUT_B, OUT_BA, OUT_A and WAIT_CLEAR. In the transitions below, a/b are the debounced levels.
REQ-014 From IDLE, the FSM SHALL go to IN_A on a&!b, to OUT_B on !a&b, and to WAIT_CLEAR on a&b (ambiguous start).
REQ-015 Inbound path transitions:
- IN_A: a&b -> IN_AB; !a&!b -> IDLE (abort).
- IN_AB: !a&b -> IN_B; a&!b -> IN_A (back-out).
- IN_B: a&b -> IN_AB; !a&!b -> IDLE with entry_detected pulsed.
REQ-016 The outbound path (OUT_B/OUT_BA/OUT_A) SHALL mirror REQ-015 with a and b swapped, and SHALL pulse exit_detected on the final both-clear.
REQ-017 Any sensor combination not listed for a state SHALL leave the FSM in that state.
REQ-018 WAIT_CLEAR SHALL return to IDLE only on !a&!b, without pulsing either output.
REQ-019 entry_detected and exit_detected SHALL be registered and asserted for exactly one cycle, on the same edge as the transition to IDLE; they SHALL never be high together.
REQ-020 Latency from the final raw sensor clearing to the pulse SHALL be 2 + DEBOUNCE_CYCLES + 1 cycles, which is 7 at the defaults.
REQ-021 A dwell counter of width $clog2(TIMEOUT_CYCLES+1) SHALL clear on every state change and while in IDLE or WAIT_CLEAR, and SHALL saturate rather than wrap.
REQ-022 When the dwell counter reaches TIMEOUT_CYCLES in any IN_*/OUT_* state, the block SHALL set fault and move to WAIT_CLEAR with no pulse.
REQ-023 fault SHALL clear only on reset.
REQ-024 The block SHALL apply no capacity gating; full and empty policy belongs to the counter.

Reset
REQ-025 Asserting reset_n low SHALL immediately force the following values:
- FSM to IDLE;
- synchronizer flops, debounced levels and debounce counters to 0;
- dwell counter to 0;
- entry_detected, exit_detected, busy and fault to 0.
REQ-026 Reset asserted mid-passage SHALL discard the partial passage: no pulse during or after reset.
REQ-027 If a sensor is still blocked when reset_n is released, the FSM SHALL follow REQ-014, so a car left straddling the beams reaches WAIT_CLEAR and is never counted.

Structure
REQ-028 A shared package garage_pkg SHALL hold the FSM state enum and the default DEBOUNCE_CYCLES and TIMEOUT_CYCLES constants.
REQ-029 The synchronizer plus debouncer SHALL be one sub-module, sensor_debounce, instantiated twice.
REQ-030 The FSM, dwell counter and output registers SHALL live in car_detector.

Verification
REQ-031 Inbound pass: a=1; a=1,b=1; b=1; both 0, each level held 10 cycles -> exactly one entry_detected pulse, 7 cycles after b falls; exit_detected stays 0.
REQ-032 Outbound pass: mirror of REQ-031 -> exactly one exit_detected pulse; busy high from OUT_B entry until the pulse edge.
REQ-033 Glitch and abort: a 3-cycle pulse on sensor_a -> no state change; then a=1 for 10 cycles followed by a=0 -> IN_A then IDLE, no pulse.
REQ-034 Back-out: a; a,b; a only; both clear -> no pulse; repeating the full inbound pass afterwards -> one entry_detected.
REQ-035 Timeout: hold a=1 for 1100 cycles -> fault=1 and WAIT_CLEAR at dwell 1000; releasing a -> IDLE with fault still 1 and no pulse.
REQ-036 Reset mid-passage: assert reset_n low while in IN_AB, then release and clear both sensors -> all outputs 0 and no entry_detected pulse.
